// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: widths, reset PC, PC step and the
// {pc, instr} buffer entry shared by the fetch unit.
package ifu_fetch_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] IFU_RESET_PC =
    32'h8000_0000;
  localparam logic [CPU_WIDTH-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic [INS_WIDTH-1:0] instr;
  } ibuf_entry_t;

  function automatic logic [CPU_WIDTH-1:0] pc_align(
    input logic [CPU_WIDTH-1:0] pc
  );
    return {pc[CPU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: imem request/response, PCU redirect and
// decoder valid/ready bundle; master = fetch unit side.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                 o_mem_req;
  logic [CPU_WIDTH-1:0] o_mem_addr;
  logic                 i_mem_gnt;
  logic                 i_mem_rvalid;
  logic [INS_WIDTH-1:0] i_mem_rdata;
  logic                 i_redirect;
  logic [CPU_WIDTH-1:0] i_redirect_pc;
  logic                 o_valid;
  logic                 i_ready;
  logic [INS_WIDTH-1:0] o_instr;
  logic [CPU_WIDTH-1:0] o_pc;

  modport master (
    output o_mem_req, o_mem_addr,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  i_redirect, i_redirect_pc,
    output o_valid, o_instr, o_pc,
    input  i_ready
  );

  modport slave (
    input  o_mem_req, o_mem_addr,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output i_redirect, i_redirect_pc,
    input  o_valid, o_instr, o_pc,
    output i_ready
  );

endinterface

// File: rtl/ifu_fetch_ibuf.sv
// ifu_ibuf: synchronous {pc, instr} FIFO with flush.
// Ports: clk, rst_n, push/push_data, pop, flush, count, head.
module ifu_ibuf
  import ifu_fetch_pkg::*;
#(
  parameter int                   DEPTH    = 2,
  parameter int                   CW       = 3,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  ibuf_entry_t push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [CW-1:0] count,
  output ibuf_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ibuf_entry_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full FIFO still accepts a push when the head leaves
  assign do_pop  = pop & (count != '0) & ~flush;
  assign do_push = push & ~flush &
                   ((count != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: '0};
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: RV32I fetch unit, in-order imem requests,
// {pc, instr} buffer to decoder, flush on PCU redirect.
// Ports: i_clk, i_rst_n, bus (ifu_fetch_if.master).
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = IFU_RESET_PC,
  parameter int                   IBUF_DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ifu_fetch_if.master bus
);

  localparam int CW = $clog2(IBUF_DEPTH + 2) + 1;

  logic [CPU_WIDTH-1:0] fetch_pc;
  logic [CPU_WIDTH-1:0] resp_pc;
  logic [CPU_WIDTH-1:0] addr;
  logic [CPU_WIDTH-1:0] redir_pc;
  logic [CPU_WIDTH-1:0] base_pc;
  logic                 req;
  logic                 stale;
  logic [CW-1:0]        outs_cnt;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        ibuf_cnt;
  logic [CW-1:0]        outs_n;
  logic [CW-1:0]        drop_n;
  logic [CW-1:0]        ibuf_n;
  logic                 fire;
  logic                 rsp;
  logic                 push;
  logic                 pop;
  logic                 hold;
  logic                 launch;
  ibuf_entry_t          head;

  assign fire     = req & bus.i_mem_gnt;
  assign hold     = req & ~bus.i_mem_gnt;
  assign rsp      = bus.i_mem_rvalid & (outs_cnt != '0);
  assign redir_pc = pc_align(bus.i_redirect_pc);
  assign base_pc  = bus.i_redirect ? redir_pc : fetch_pc;

  // a word arriving on the redirect edge is already stale
  assign push = rsp & (drop_cnt == '0) & ~bus.i_redirect;
  assign pop  = (ibuf_cnt != '0) & bus.i_ready &
                ~bus.i_redirect;

  assign outs_n = outs_cnt + CW'(fire) - CW'(rsp);
  assign ibuf_n = bus.i_redirect ? '0 :
                  ibuf_cnt + CW'(push) - CW'(pop);

  // redirect: everything still in flight after this edge
  // is dropped; a held request granted later is added then
  always_comb begin
    drop_n = drop_cnt;
    if (bus.i_redirect) begin
      drop_n = outs_n;
    end else begin
      if (rsp && drop_cnt != '0) begin
        drop_n = drop_n - 1'b1;
      end
      if (fire && stale) begin
        drop_n = drop_n + 1'b1;
      end
    end
  end

  // credit uses post-edge counts so a slot freed this
  // cycle can be reused by the very next request
  assign launch = ~hold & (drop_n == '0) &
                  ((outs_n + ibuf_n) < CW'(IBUF_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req      <= 1'b0;
      stale    <= 1'b0;
      addr     <= RESET_PC;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outs_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      outs_cnt <= outs_n;
      drop_cnt <= drop_n;
      if (bus.i_redirect && hold) begin
        stale <= 1'b1;
      end else if (fire) begin
        stale <= 1'b0;
      end
      if (!hold) begin
        req <= launch;
      end
      if (launch) begin
        addr     <= base_pc;
        fetch_pc <= base_pc + PC_INC;
      end else begin
        fetch_pc <= base_pc;
      end
      if (bus.i_redirect) begin
        resp_pc <= redir_pc;
      end else if (push) begin
        resp_pc <= resp_pc + PC_INC;
      end
    end
  end

  ifu_ibuf #(
    .DEPTH    (IBUF_DEPTH),
    .CW       (CW),
    .RESET_PC (RESET_PC)
  ) u_ibuf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data ('{pc: resp_pc, instr: bus.i_mem_rdata}),
    .pop       (pop),
    .flush     (bus.i_redirect),
    .count     (ibuf_cnt),
    .head      (head)
  );

  assign bus.o_mem_req  = req;
  assign bus.o_mem_addr = addr;
  assign bus.o_valid    = (ibuf_cnt != '0);
  assign bus.o_instr    = head.instr;
  assign bus.o_pc       = head.pc;

endmodule
